uart_tx_stream: RTL

//  Buffered, parametrised UART transmitter; successor to the single-byte UART_tx.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/uart_tx_stream.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encodings, default widths,
// and a frame-length helper used by the TX stream and the RX path.
package uart_pkg;

    // Default width of the bit-period and inter-frame gap inputs.
    localparam int UTX_CPD_W_DEF = 10;

`ifdef UART_TX_STREAM_PARITY_EN
    localparam int UTX_PAR_BITS = 1;
`else
    localparam int UTX_PAR_BITS = 0;
`endif

    // Transmitter FSM encodings.
    typedef enum logic [2:0] {
        UTX_IDLE   = 3'd0,
        UTX_START  = 3'd1,
        UTX_DATA   = 3'd2,
        UTX_PARITY = 3'd3,
        UTX_STOP   = 3'd4,
        UTX_GAP    = 3'd5
    } utx_state_e;

    // Clock cycles occupied by one frame; a bit period of 0 counts as 1.
    function automatic int utx_frame_cycles(
        input int data_bits,
        input int parity_bits,
        input int stop_bits,
        input int cpd
    );
        int c;
        c = (cpd == 0) ? 1 : cpd;
        return (1 + data_bits + parity_bits + stop_bits) * c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, full and empty flags.
// Head word is visible on rd_data whenever the FIFO is not empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push;
    logic             pop;

    // A write into a full FIFO is dropped even if a pop happens that cycle.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: FIFO-fed, back-to-back frames, LSB first.
// Optional parity bit enabled by defining UART_TX_STREAM_PARITY_EN.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CPD_W      = UTX_CPD_W_DEF,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [CPD_W-1:0]              cycles_per_databit,
    input  logic [CPD_W-1:0]              byte_spacing,
`ifdef UART_TX_STREAM_PARITY_EN
    input  logic                          parity_odd,
`endif
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          tx_line
);

    localparam int BW = 4;

    utx_state_e           state_q;
    logic [CPD_W-1:0]     cnt_q;
    logic [CPD_W-1:0]     cpd_q;
    logic [CPD_W-1:0]     gap_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BW-1:0]        bit_q;
    logic                 tx_line_q;
    logic                 tx_done_q;
    logic                 overflow_q;
`ifdef UART_TX_STREAM_PARITY_EN
    logic                 par_q;
    logic                 par_d;
`endif

    logic [DATA_BITS-1:0] head;
    logic [CPD_W-1:0]     cpd_d;
    logic                 cnt_last;
    logic                 stop_last;
    logic                 gap_last;
    logic                 frame_end;
    logic                 pop;
    logic                 line_d;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign cpd_d     = (cycles_per_databit == '0) ? CPD_W'(1)
                                                  : cycles_per_databit;
    assign cnt_last  = (cnt_q == CPD_W'(1));
    assign stop_last = (state_q == UTX_STOP) && cnt_last
                       && (bit_q == BW'(STOP_BITS - 1));
    assign gap_last  = (state_q == UTX_GAP) && cnt_last;
    // A frame (plus its gap) is over; the next word may start right away.
    assign frame_end = (stop_last && (gap_q == '0)) || gap_last;
    assign pop       = !empty && ((state_q == UTX_IDLE) || frame_end);

`ifdef UART_TX_STREAM_PARITY_EN
    // Even parity makes the total count of ones even; odd flips it.
    assign par_d = (^head) ^ parity_odd;
`endif

    assign busy     = (state_q != UTX_IDLE);
    assign tx_done  = tx_done_q;
    assign tx_line  = tx_line_q;
    assign overflow = overflow_q;

    // Line level implied by the current state; registered one edge later.
    always_comb begin
        line_d = 1'b1;
        unique case (state_q)
            UTX_START:  line_d = 1'b0;
            UTX_DATA:   line_d = shift_q[0];
`ifdef UART_TX_STREAM_PARITY_EN
            UTX_PARITY: line_d = par_q;
`endif
            default:    line_d = 1'b1;
        endcase
    end

    // Transmit FSM: frame sequencing, bit timing and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= UTX_IDLE;
            cnt_q     <= '0;
            cpd_q     <= CPD_W'(1);
            gap_q     <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            tx_line_q <= 1'b1;
            tx_done_q <= 1'b0;
`ifdef UART_TX_STREAM_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            tx_line_q <= line_d;
            tx_done_q <= stop_last;
            if (pop) begin
                shift_q <= head;
                cpd_q   <= cpd_d;
                gap_q   <= byte_spacing;
                cnt_q   <= cpd_d;
                bit_q   <= '0;
`ifdef UART_TX_STREAM_PARITY_EN
                par_q   <= par_d;
`endif
                state_q <= UTX_START;
            end else begin
                unique case (state_q)
                    UTX_IDLE: begin
                        state_q <= UTX_IDLE;
                    end
                    UTX_START: begin
                        if (cnt_last) begin
                            cnt_q   <= cpd_q;
                            bit_q   <= '0;
                            state_q <= UTX_DATA;
                        end else begin
                            cnt_q <= cnt_q - CPD_W'(1);
                        end
                    end
                    UTX_DATA: begin
                        if (cnt_last) begin
                            cnt_q   <= cpd_q;
                            shift_q <= shift_q >> 1;
                            if (bit_q == BW'(DATA_BITS - 1)) begin
                                bit_q <= '0;
`ifdef UART_TX_STREAM_PARITY_EN
                                state_q <= UTX_PARITY;
`else
                                state_q <= UTX_STOP;
`endif
                            end else begin
                                bit_q <= bit_q + BW'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q - CPD_W'(1);
                        end
                    end
`ifdef UART_TX_STREAM_PARITY_EN
                    UTX_PARITY: begin
                        if (cnt_last) begin
                            cnt_q   <= cpd_q;
                            bit_q   <= '0;
                            state_q <= UTX_STOP;
                        end else begin
                            cnt_q <= cnt_q - CPD_W'(1);
                        end
                    end
`endif
                    UTX_STOP: begin
                        if (cnt_last) begin
                            if (bit_q == BW'(STOP_BITS - 1)) begin
                                if (gap_q != '0) begin
                                    cnt_q   <= gap_q;
                                    state_q <= UTX_GAP;
                                end else begin
                                    state_q <= UTX_IDLE;
                                end
                            end else begin
                                bit_q <= bit_q + BW'(1);
                                cnt_q <= cpd_q;
                            end
                        end else begin
                            cnt_q <= cnt_q - CPD_W'(1);
                        end
                    end
                    UTX_GAP: begin
                        if (cnt_last) begin
                            state_q <= UTX_IDLE;
                        end else begin
                            cnt_q <= cnt_q - CPD_W'(1);
                        end
                    end
                    default: begin
                        state_q <= UTX_IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky flag: a write was attempted while the FIFO was full.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else if (wr_en && full) begin
            overflow_q <= 1'b1;
        end
    end

endmodule
